uart_tx_ctrl: RTL

UART transmit controller that sits directly upstream of the UART TX shift register. It accepts one byte at a time over a valid/ready handshake and generates the register's `load_byte_i` and `shift_i` pulses at the baud rate. It also muxes the register's serial output onto the final TX line: idle-high and stop bits are driven here, while start and data bits come from the shift register.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_ctrl_if.sv | 27 ++
 rtl/uart_baud_counter.sv | 37 +++
 rtl/uart_tx_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX controller state encoding and frame geometry.
// Used by the TX controller today and the RX path later.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } uart_tx_state_e;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_FRAME_SHIFTS = 8;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake, shift-register control and TX line bundle for uart_tx_ctrl.
// slave = the controller, master = whatever drives bytes and models the shifter.
interface uart_tx_ctrl_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data_i;
  logic                      tx_valid_i;
  logic                      tx_ready_o;
  logic [UART_DATA_BITS-1:0] data_o;
  logic                      load_byte_o;
  logic                      shift_o;
  logic                      serial_i;
  logic                      tx_o;
  logic                      busy_o;
  logic                      done_o;

  modport slave (
    input  tx_data_i, tx_valid_i, serial_i,
    output tx_ready_o, data_o, load_byte_o, shift_o, tx_o, busy_o, done_o
  );

  modport master (
    output tx_data_i, tx_valid_i, serial_i,
    input  tx_ready_o, data_o, load_byte_o, shift_o, tx_o, busy_o, done_o
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, wraps.
// Latency: tick_o is combinational from the count; no backpressure (clear wins over enable).
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX sequencer: accepts a byte, pulses load/shift for the shift register, muxes the line.
// Latency: load 1 cycle after accept, frame 2+10*CPB cycles (2+11*CPB with UART_TX_TWO_STOP_EN).
// Backpressure: tx_ready_o only in IDLE; offers while busy are dropped, not queued.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input logic           clk_i,
  input logic           reset_ni,
  uart_tx_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_DATA = DATA;
  localparam logic [1:0] ST_STOP = STOP;

`ifdef UART_TX_TWO_STOP_EN
  localparam logic [3:0] STOP_LAST = 4'd1;
`else
  localparam logic [3:0] STOP_LAST = 4'd0;
`endif

  logic [1:0]                state_q, state_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      line_en_q, line_en_d;
  logic                      baud_tick;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clear_i (state_q == ST_LOAD),
    .enable_i((state_q == ST_DATA) || (state_q == ST_STOP)),
    .tick_o  (baud_tick)
  );

  // bit_cnt_q is the line bit index in DATA and the stop-bit index in STOP.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    line_en_d = (state_q == ST_DATA);
    case (state_q)
      ST_IDLE: begin
        if (bus.tx_valid_i) begin
          data_d  = bus.tx_data_i;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bit_cnt_d = '0;
        state_d   = ST_DATA;
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == 4'(UART_DATA_BITS)) begin
            bit_cnt_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        if (baud_tick) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      line_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      line_en_q <= line_en_d;
    end
  end

  // line_en_q lags DATA by one cycle to line up with the shifter's registered output.
  assign bus.tx_o        = line_en_q ? bus.serial_i : 1'b1;
  assign bus.tx_ready_o  = (state_q == ST_IDLE);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.data_o      = data_q;
  assign bus.load_byte_o = (state_q == ST_LOAD);
  assign bus.shift_o     = (state_q == ST_DATA) && baud_tick &&
                           (bit_cnt_q < 4'(UART_FRAME_SHIFTS));
  assign bus.done_o      = (state_q == ST_STOP) && baud_tick && (bit_cnt_q == STOP_LAST);

endmodule
